// File: rtl/noc_packet_injector.sv
// noc_packet_injector
// Lets an operator choose a payload and a target router with board switches
// and keys. It then injects one packet, or a repeating stream, into that
// router's local input over a valid/ack handshake. A stalled handshake is
// dropped after a timeout and reported through a sticky error flag.
//
// Ports
//   clk            system clock
//   rst            synchronous active-high reset
//   sw_on          injection enable (asynchronous board switch)
//   sw_mode        0 = one-shot, 1 = continuous
//   sw_sel_data    keys edit the payload
//   sw_sel_router  keys edit the router index (has priority over sw_sel_data)
//   key_inc        increment key, active-high, asynchronous
//   key_dec        decrement key, active-high, asynchronous
//   ack            per-router accept, bit i from router i
//   out_flat       slot i = bits [i*PKT_W +: PKT_W]; MSB of each slot = valid
//   busy           high while sending or waiting between packets
//   err            sticky timeout flag, cleared when the next injection starts
//   hex_data_hi/lo     payload bits [7:4] / [3:0], active-low 7-segment a..g
//   hex_router_hi/lo   router index (zero-extended to 8 bits), 7-segment
module noc_packet_injector #(
    parameter int unsigned ROUTERS    = 25,
    parameter int unsigned ID_BITS    = 5,
    parameter int unsigned DATA_BITS  = 12,
    parameter int unsigned GAP_CYCLES = 1000,
    parameter int unsigned TIMEOUT    = 65535
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 sw_on,
    input  logic                                 sw_mode,
    input  logic                                 sw_sel_data,
    input  logic                                 sw_sel_router,
    input  logic                                 key_inc,
    input  logic                                 key_dec,
    input  logic [ROUTERS-1:0]                   ack,
    output logic [ROUTERS*(DATA_BITS+1)-1:0]     out_flat,
    output logic                                 busy,
    output logic                                 err,
    output logic [6:0]                           hex_data_hi,
    output logic [6:0]                           hex_data_lo,
    output logic [6:0]                           hex_router_hi,
    output logic [6:0]                           hex_router_lo
);

    localparam int unsigned PKT_W   = DATA_BITS + 1;
    localparam int unsigned OUT_W   = ROUTERS * PKT_W;
    localparam int unsigned TMO_LOG = $clog2(TIMEOUT);
    localparam int unsigned GAP_LOG = $clog2(GAP_CYCLES);
    // One counter serves both the ack timeout and the inter-packet gap.
    localparam int unsigned CNT_W   = ((TMO_LOG > GAP_LOG) ? TMO_LOG : GAP_LOG) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Active-low a..g (bit6 = a) pattern for one hex digit.
    function automatic logic [6:0] f_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // Synchroniser chains: [0],[1] are the 2-flop synchroniser, [2] the edge history.
    logic [2:0]           r_on_sh;
    logic [2:0]           r_inc_sh;
    logic [2:0]           r_dec_sh;

    logic [ID_BITS-1:0]   r_router;
    logic [DATA_BITS-1:0] r_data;
    logic [ID_BITS-1:0]   r_pkt_router;
    logic [DATA_BITS-1:0] r_pkt_data;
    logic [CNT_W-1:0]     r_cnt;
    logic [OUT_W-1:0]     r_out;
    logic                 r_busy;
    logic                 r_err;
    logic [6:0]           r_hex_data_hi;
    logic [6:0]           r_hex_data_lo;
    logic [6:0]           r_hex_router_hi;
    logic [6:0]           r_hex_router_lo;
    state_t               r_state;

    logic                 w_on_lvl;
    logic                 w_on_rise;
    logic                 w_inc_rise;
    logic                 w_dec_rise;
    logic                 w_inc;
    logic                 w_dec;
    logic                 w_ack_hit;
    logic                 w_timeout;
    logic                 w_gap_end;
    logic [ID_BITS-1:0]   w_router_nxt;
    logic [DATA_BITS-1:0] w_data_nxt;
    logic [ID_BITS-1:0]   w_pkt_router_nxt;
    logic [DATA_BITS-1:0] w_pkt_data_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [OUT_W-1:0]     w_out_nxt;
    logic                 w_busy_nxt;
    logic                 w_err_nxt;
    logic [7:0]           w_data8;
    logic [7:0]           w_router8;
    state_t               w_state_nxt;

    // Input synchronisers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_on_sh  <= '0;
            r_inc_sh <= '0;
            r_dec_sh <= '0;
        end else begin
            r_on_sh  <= {r_on_sh[1:0],  sw_on};
            r_inc_sh <= {r_inc_sh[1:0], key_inc};
            r_dec_sh <= {r_dec_sh[1:0], key_dec};
        end
    end

    assign w_on_lvl   = r_on_sh[1];
    assign w_on_rise  = r_on_sh[1]  & ~r_on_sh[2];
    assign w_inc_rise = r_inc_sh[1] & ~r_inc_sh[2];
    assign w_dec_rise = r_dec_sh[1] & ~r_dec_sh[2];
    // Simultaneous inc and dec cancel out.
    assign w_inc      = w_inc_rise & ~w_dec_rise;
    assign w_dec      = w_dec_rise & ~w_inc_rise;

    // Operator edit of router index / payload
    always_comb begin
        w_router_nxt = r_router;
        w_data_nxt   = r_data;
        if (sw_sel_router) begin
            if (w_inc) begin
                w_router_nxt = (r_router == ID_BITS'(ROUTERS - 1)) ? '0
                                                                   : r_router + ID_BITS'(1);
            end else if (w_dec) begin
                w_router_nxt = (r_router == '0) ? ID_BITS'(ROUTERS - 1)
                                                : r_router - ID_BITS'(1);
            end
        end else if (sw_sel_data) begin
            if (w_inc) begin
                w_data_nxt = r_data + DATA_BITS'(1);
            end else if (w_dec) begin
                w_data_nxt = r_data - DATA_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_router <= '0;
            r_data   <= '0;
        end else begin
            r_router <= w_router_nxt;
            r_data   <= w_data_nxt;
        end
    end

    // Display registers follow the edit registers one cycle later.
    assign w_data8   = 8'(r_data);
    assign w_router8 = 8'(r_router);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hex_data_hi   <= 7'b0000001;
            r_hex_data_lo   <= 7'b0000001;
            r_hex_router_hi <= 7'b0000001;
            r_hex_router_lo <= 7'b0000001;
        end else begin
            r_hex_data_hi   <= f_seg(w_data8[7:4]);
            r_hex_data_lo   <= f_seg(w_data8[3:0]);
            r_hex_router_hi <= f_seg(w_router8[7:4]);
            r_hex_router_lo <= f_seg(w_router8[3:0]);
        end
    end

    // Ack from the targeted router only; other routers' acks are ignored.
    always_comb begin
        w_ack_hit = 1'b0;
        for (int i = 0; i < int'(ROUTERS); i++) begin
            if (r_pkt_router == ID_BITS'(i)) begin
                w_ack_hit = ack[i];
            end
        end
    end

    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_gap_end = (r_cnt == CNT_W'(GAP_CYCLES - 1));

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state; dropping sw_on aborts from any state
    always_comb begin
        w_state_nxt = r_state;
        if (!w_on_lvl) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_on_rise) w_state_nxt = S_SEND;
                S_SEND: begin
                    if (w_ack_hit) begin
                        w_state_nxt = sw_mode ? S_GAP : S_DONE;
                    end else if (w_timeout) begin
                        w_state_nxt = S_DONE;
                    end
                end
                S_GAP:  if (w_gap_end) w_state_nxt = S_SEND;
                S_DONE: w_state_nxt = S_DONE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // FSM outputs: next values of the registered outputs and packet latches.
    // The slot is driven from the next state so valid shows in the first SEND cycle.
    always_comb begin
        w_pkt_router_nxt = r_pkt_router;
        w_pkt_data_nxt   = r_pkt_data;
        w_cnt_nxt        = '0;
        w_err_nxt        = r_err;
        w_out_nxt        = '0;
        w_busy_nxt       = (w_state_nxt == S_SEND) || (w_state_nxt == S_GAP);

        if ((r_state != S_SEND) && (w_state_nxt == S_SEND)) begin
            w_pkt_router_nxt = r_router;
            w_pkt_data_nxt   = r_data;
        end

        if ((r_state == S_IDLE) && (w_state_nxt == S_SEND)) begin
            w_err_nxt = 1'b0;
        end

        if ((r_state == S_SEND) && !w_ack_hit && w_timeout && (w_state_nxt == S_DONE)) begin
            w_err_nxt = 1'b1;
        end

        if (((r_state == S_SEND) && (w_state_nxt == S_SEND)) ||
            ((r_state == S_GAP)  && (w_state_nxt == S_GAP))) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end

        if (w_state_nxt == S_SEND) begin
            for (int i = 0; i < int'(ROUTERS); i++) begin
                if (w_pkt_router_nxt == ID_BITS'(i)) begin
                    w_out_nxt[i*PKT_W +: PKT_W] = {1'b1, w_pkt_data_nxt};
                end
            end
        end
    end

    // Packet latches, counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_router <= '0;
            r_pkt_data   <= '0;
            r_cnt        <= '0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
            r_out        <= '0;
        end else begin
            r_pkt_router <= w_pkt_router_nxt;
            r_pkt_data   <= w_pkt_data_nxt;
            r_cnt        <= w_cnt_nxt;
            r_err        <= w_err_nxt;
            r_busy       <= w_busy_nxt;
            r_out        <= w_out_nxt;
        end
    end

    assign out_flat      = r_out;
    assign busy          = r_busy;
    assign err           = r_err;
    assign hex_data_hi   = r_hex_data_hi;
    assign hex_data_lo   = r_hex_data_lo;
    assign hex_router_hi = r_hex_router_hi;
    assign hex_router_lo = r_hex_router_lo;

endmodule

// File: tb/tb_noc_packet_injector.sv
// Directed bench for noc_packet_injector with a short gap and timeout.
module tb_noc_packet_injector;

    localparam int ROUTERS = 25;
    localparam int ID_BITS = 5;
    localparam int DBITS   = 12;
    localparam int PKT_W   = DBITS + 1;
    localparam int OUT_W   = ROUTERS * PKT_W;
    localparam int GAP     = 4;
    localparam int TMO     = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               sw_on = 1'b0;
    logic               sw_mode = 1'b0;
    logic               sw_sel_data = 1'b0;
    logic               sw_sel_router = 1'b0;
    logic               key_inc = 1'b0;
    logic               key_dec = 1'b0;
    logic [ROUTERS-1:0] ack = '0;
    logic [OUT_W-1:0]   out_flat;
    logic               busy;
    logic               err;
    logic [6:0]         hex_data_hi;
    logic [6:0]         hex_data_lo;
    logic [6:0]         hex_router_hi;
    logic [6:0]         hex_router_lo;

    noc_packet_injector #(
        .ROUTERS   (ROUTERS),
        .ID_BITS   (ID_BITS),
        .DATA_BITS (DBITS),
        .GAP_CYCLES(GAP),
        .TIMEOUT   (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sw_on        (sw_on),
        .sw_mode      (sw_mode),
        .sw_sel_data  (sw_sel_data),
        .sw_sel_router(sw_sel_router),
        .key_inc      (key_inc),
        .key_dec      (key_dec),
        .ack          (ack),
        .out_flat     (out_flat),
        .busy         (busy),
        .err          (err),
        .hex_data_hi  (hex_data_hi),
        .hex_data_lo  (hex_data_lo),
        .hex_router_hi(hex_router_hi),
        .hex_router_lo(hex_router_lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               r;
        logic [DBITS-1:0] d;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   m_router = 0;
    int   m_data   = 0;

    function automatic logic [6:0] seg(input logic [3:0] d);
        logic [6:0] t [16];
        t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
              7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        return t[d];
    endfunction

    function automatic logic [OUT_W-1:0] pkt_vec(input int r, input logic [DBITS-1:0] d);
        logic [OUT_W-1:0] v;
        v = '0;
        v[r*PKT_W +: PKT_W] = {1'b1, d};
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One key press plus settle time; the model steps router/data by itself.
    task automatic press(input logic inc, input logic dec);
        key_inc = inc;
        key_dec = dec;
        repeat (4) tick();
        key_inc = 1'b0;
        key_dec = 1'b0;
        repeat (3) tick();
        if (inc != dec) begin
            if (sw_sel_router)
                m_router = inc ? (m_router + 1) % ROUTERS : (m_router + ROUTERS - 1) % ROUTERS;
            else if (sw_sel_data)
                m_data = inc ? (m_data + 1) % 4096 : (m_data + 4095) % 4096;
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.r = m_router;
        e.d = DBITS'(m_data);
        sb.push_back(e);
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk_vec(tag, out_flat, pkt_vec(e.r, e.d));
        end
    endtask

    task automatic wait_valid(input int bound, output int n);
        n = 0;
        while (out_flat == '0 && n < bound) begin
            tick();
            n++;
        end
        chk("valid_seen", 32'(out_flat != '0), 32'd1);
    endtask

    initial begin
        int n;
        int vc;

        // Reset
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();
        chk_vec("rst_out", out_flat, '0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_hdh", 32'(hex_data_hi), 32'(seg(4'h0)));
        chk("rst_hdl", 32'(hex_data_lo), 32'(seg(4'h0)));
        chk("rst_hrh", 32'(hex_router_hi), 32'(seg(4'h0)));
        chk("rst_hrl", 32'(hex_router_lo), 32'b0000001);

        // Router editing with wrap in both directions
        sw_sel_router = 1'b1;
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        chk("router2_lo", 32'(hex_router_lo), 32'(seg(4'(m_router))));
        repeat (3) press(1'b0, 1'b1);
        chk("router24_hi", 32'(hex_router_hi), 32'b1001111);
        chk("router24_lo", 32'(hex_router_lo), 32'b0000000);
        press(1'b1, 1'b0);
        chk("router_wrap_up", 32'(hex_router_lo), 32'(seg(4'h0)));
        repeat (7) press(1'b1, 1'b0);
        chk("router7_lo", 32'(hex_router_lo), 32'(seg(4'h7)));

        // Data editing: held key steps once only
        sw_sel_router = 1'b0;
        sw_sel_data   = 1'b1;
        key_inc = 1'b1;
        repeat (10) tick();
        key_inc = 1'b0;
        repeat (3) tick();
        m_data = m_data + 1;
        chk("held_key_once", 32'(hex_data_lo), 32'(seg(4'h1)));
        repeat (164) press(1'b1, 1'b0);
        chk("data_a5_hi", 32'(hex_data_hi), 32'(seg(4'hA)));
        chk("data_a5_lo", 32'(hex_data_lo), 32'(seg(4'h5)));
        press(1'b1, 1'b1);
        chk("inc_dec_cancel", 32'(hex_data_lo), 32'(seg(4'h5)));

        // Router select has priority over data select
        sw_sel_router = 1'b1;
        press(1'b1, 1'b0);
        chk("prio_router", 32'(hex_router_lo), 32'(seg(4'h8)));
        chk("prio_data", 32'(hex_data_lo), 32'(seg(4'h5)));
        press(1'b0, 1'b1);
        sw_sel_router = 1'b0;

        // One-shot, ack 4 cycles after valid
        sw_mode = 1'b0;
        push_exp();
        sw_on = 1'b1;
        wait_valid(10, n);
        chk("launch_latency", n, 3);
        sb_check("oneshot_pkt");
        chk("oneshot_pkt_10a5", 32'(out_flat[7*PKT_W +: PKT_W]), 32'h10A5);
        chk("oneshot_busy", 32'(busy), 32'd1);
        vc = 1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (out_flat == pkt_vec(7, 12'h0A5)) vc++;
        end
        ack[7] = 1'b1;
        tick();
        ack[7] = 1'b0;
        chk("oneshot_valid_len", vc, 5);
        chk_vec("oneshot_cleared", out_flat, '0);
        chk("oneshot_done_busy", 32'(busy), 32'd0);
        chk("oneshot_err", 32'(err), 32'd0);
        vc = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (out_flat != '0) vc++;
        end
        chk("oneshot_no_repeat", vc, 0);
        sw_on = 1'b0;
        repeat (4) tick();

        // Continuous with ack held, data edited mid-stream
        sw_mode = 1'b1;
        ack[7]  = 1'b1;
        push_exp();
        sw_on = 1'b1;
        wait_valid(10, n);
        sb_check("cont_pkt1");
        key_inc = 1'b1;
        m_data  = m_data + 1;
        push_exp();
        push_exp();
        tick();
        chk_vec("cont_pulse1", out_flat, '0);
        chk("cont_busy_gap", 32'(busy), 32'd1);
        repeat (3) tick();
        key_inc = 1'b0;
        wait_valid(10, n);
        chk("cont_period2", n + 4, 1 + GAP);
        sb_check("cont_pkt2");
        tick();
        chk_vec("cont_pulse2", out_flat, '0);
        wait_valid(10, n);
        chk("cont_period3", n + 1, 1 + GAP);
        sb_check("cont_pkt3");
        sw_on = 1'b0;
        ack   = '0;
        repeat (4) tick();
        chk("cont_stop_busy", 32'(busy), 32'd0);
        chk_vec("cont_stop_out", out_flat, '0);

        // Timeout with a wrong-router ack present
        sw_mode = 1'b0;
        ack[3]  = 1'b1;
        push_exp();
        sw_on = 1'b1;
        wait_valid(10, n);
        sb_check("tmo_pkt");
        chk("tmo_err_low", 32'(err), 32'd0);
        vc = 1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (out_flat == '0) break;
            vc++;
        end
        chk("tmo_valid_len", vc, TMO);
        chk("tmo_err_set", 32'(err), 32'd1);
        chk_vec("tmo_out_zero", out_flat, '0);
        chk("tmo_busy", 32'(busy), 32'd0);
        sw_on = 1'b0;
        ack   = '0;
        repeat (4) tick();
        chk("tmo_err_sticky", 32'(err), 32'd1);

        // sw_on dropped during SEND
        push_exp();
        sw_on = 1'b1;
        wait_valid(10, n);
        sb_check("drop_pkt");
        chk("drop_err_cleared", 32'(err), 32'd0);
        repeat (2) tick();
        sw_on = 1'b0;
        n = 0;
        while (out_flat != '0 && n < 6) begin
            tick();
            n++;
        end
        chk("drop_clear_cycles", n, 3);
        chk("drop_busy", 32'(busy), 32'd0);
        repeat (3) tick();

        // Reset mid-transfer
        push_exp();
        sw_on = 1'b1;
        wait_valid(10, n);
        sb_check("rst_pkt");
        rst   = 1'b1;
        sw_on = 1'b0;
        tick();
        chk_vec("midrst_out", out_flat, '0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_hex_router", 32'(hex_router_lo), 32'b0000001);
        chk("midrst_hex_data", 32'(hex_data_hi), 32'b0000001);
        rst = 1'b0;
        m_data   = 0;
        m_router = 0;
        repeat (3) tick();
        chk_vec("post_rst_out", out_flat, '0);
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
